ebus_master_arb: RTL and testbench

EBUS_MASTER_ARB -- requirements
Module: ebus_master_arb

---
 rtl/ebus_master_arb.sv | 174 +++++++++++++++++
 tb/tb_ebus_master_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_master_arb.sv
// EBUS master arbiter: round-robin grant among NREQ requesters, then one
// SETUP/DEMAND/HOLD/DONE bus transaction for the winner, with DEMAND timeout.
module ebus_master_arb #(
  parameter int NREQ = 4,
  parameter int TMO  = 255
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic [NREQ-1:0]      rq_h,
  input  logic [NREQ*7-1:0]    rq_cs_h,
  input  logic [NREQ*3-1:0]    rq_func_h,
  input  logic [NREQ*36-1:0]   rq_wdata_h,
  output logic [NREQ-1:0]      gnt_h,
  output logic [NREQ-1:0]      done_h,
  output logic                 tmo_h,
  output logic [35:0]          rdata_h,
  output logic [6:0]           ebus_cs_h,
  output logic [2:0]           ebus_func_h,
  output logic                 ebus_demand_h,
  output logic                 ebus_drive_h,
  output logic [35:0]          ebus_dout_h,
  input  logic                 ebus_xfer_h,
  input  logic [35:0]          ebus_din_h
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_DEMAND,
    S_HOLD,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            tmo_q, tmo_d;
  logic [35:0]     rdata_q, rdata_d;
  logic [6:0]      cs_q, cs_d;
  logic [2:0]      func_q, func_d;
  logic [35:0]     wdata_q, wdata_d;
  logic            demand_q, demand_d;
  logic            drive_q, drive_d;
  logic [35:0]     dout_q, dout_d;

  logic            found;
  logic [IW-1:0]   win;

  // Round-robin search starting just after the last granted index.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(last_q) + 1 + k) % NREQ;
      if (!found && rq_h[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    tmo_d   = 1'b0;
    rdata_d = rdata_q;
    cs_d    = cs_q;
    func_d  = func_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_SETUP;
          last_d  = win;
          gnt_d   = NREQ'(1) << win;
          cs_d    = rq_cs_h[int'(win)*7 +: 7];
          func_d  = rq_func_h[int'(win)*3 +: 3];
          wdata_d = rq_wdata_h[int'(win)*36 +: 36];
        end
      end
      S_SETUP: begin
        state_d = S_DEMAND;
        cnt_d   = '0;
      end
      S_DEMAND: begin
        // An acknowledge on the timeout cycle still counts as a good transfer.
        if (ebus_xfer_h) begin
          rdata_d = func_q[2] ? '0 : ebus_din_h;
          state_d = S_HOLD;
        end else if (cnt_q == 8'(TMO)) begin
          rdata_d = '0;
          tmo_d   = 1'b1;
          done_d  = gnt_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (!ebus_xfer_h) begin
          done_d  = gnt_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
        cs_d    = '0;
        func_d  = '0;
        wdata_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    demand_d = (state_d == S_DEMAND);
    drive_d  = (state_d inside {S_SETUP, S_DEMAND, S_HOLD}) && func_d[2];
    dout_d   = drive_d ? wdata_d : '0;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= S_IDLE;
      last_q   <= IW'(NREQ - 1);
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      tmo_q    <= 1'b0;
      rdata_q  <= '0;
      cs_q     <= '0;
      func_q   <= '0;
      wdata_q  <= '0;
      demand_q <= 1'b0;
      drive_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      rdata_q  <= rdata_d;
      cs_q     <= cs_d;
      func_q   <= func_d;
      wdata_q  <= wdata_d;
      demand_q <= demand_d;
      drive_q  <= drive_d;
      dout_q   <= dout_d;
    end
  end

  assign gnt_h         = gnt_q;
  assign done_h        = done_q;
  assign tmo_h         = tmo_q;
  assign rdata_h       = rdata_q;
  assign ebus_cs_h     = cs_q;
  assign ebus_func_h   = func_q;
  assign ebus_demand_h = demand_q;
  assign ebus_drive_h  = drive_q;
  assign ebus_dout_h   = dout_q;

endmodule

// File: tb/tb_ebus_master_arb.sv
// Self-checking bench for ebus_master_arb: scripted slave responses and a
// completion scoreboard popped on every done_h pulse.
module tb_ebus_master_arb;

  localparam int NREQ = 4;
  localparam int TMO  = 5;

  logic                 clk;
  logic                 reset_l;
  logic [NREQ-1:0]      rq_h;
  logic [NREQ*7-1:0]    rq_cs_h;
  logic [NREQ*3-1:0]    rq_func_h;
  logic [NREQ*36-1:0]   rq_wdata_h;
  logic [NREQ-1:0]      gnt_h;
  logic [NREQ-1:0]      done_h;
  logic                 tmo_h;
  logic [35:0]          rdata_h;
  logic [6:0]           ebus_cs_h;
  logic [2:0]           ebus_func_h;
  logic                 ebus_demand_h;
  logic                 ebus_drive_h;
  logic [35:0]          ebus_dout_h;
  logic                 ebus_xfer_h;
  logic [35:0]          ebus_din_h;

  ebus_master_arb #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .rq_h         (rq_h),
    .rq_cs_h      (rq_cs_h),
    .rq_func_h    (rq_func_h),
    .rq_wdata_h   (rq_wdata_h),
    .gnt_h        (gnt_h),
    .done_h       (done_h),
    .tmo_h        (tmo_h),
    .rdata_h      (rdata_h),
    .ebus_cs_h    (ebus_cs_h),
    .ebus_func_h  (ebus_func_h),
    .ebus_demand_h(ebus_demand_h),
    .ebus_drive_h (ebus_drive_h),
    .ebus_dout_h  (ebus_dout_h),
    .ebus_xfer_h  (ebus_xfer_h),
    .ebus_din_h   (ebus_din_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [35:0] rdata;
    logic        tmo;
    int          dem;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   dem_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push_exp(input int idx, input logic [35:0] rdata, input logic tmo, input int dem);
    exp_t e;
    e.idx = idx; e.rdata = rdata; e.tmo = tmo; e.dem = dem;
    exp_q.push_back(e);
  endtask

  // Completion monitor: compares each done_h pulse with the oldest expectation.
  always @(negedge clk) begin
    if (!reset_l) begin
      dem_cnt = 0;
    end else begin
      if (ebus_demand_h) dem_cnt++;
      if (done_h != '0) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 64'(done_h), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_onehot", 64'(done_h), 64'(4'b0001 << e.idx));
          check("done_gnt", 64'(gnt_h), 64'(4'b0001 << e.idx));
          check("done_rdata", 64'(rdata_h), 64'(e.rdata));
          check("done_tmo", 64'(tmo_h), 64'(e.tmo));
          if (e.dem >= 0) check("done_demand_cycles", 64'(dem_cnt), 64'(e.dem));
        end
        dem_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [6:0] cs, input logic [2:0] func, input logic [35:0] wd);
    rq_cs_h[i*7 +: 7]     = cs;
    rq_func_h[i*3 +: 3]   = func;
    rq_wdata_h[i*36 +: 36] = wd;
  endtask

  task automatic wait_demand();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (ebus_demand_h) ok = 1'b1;
    end
    if (!ok) check("timeout_wait_demand", 64'd0, 64'd1);
  endtask

  task automatic wait_gnt();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (gnt_h != '0) ok = 1'b1;
    end
    if (!ok) check("timeout_wait_gnt", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (gnt_h == '0) ok = 1'b1;
    end
    if (!ok) check("timeout_wait_idle", 64'd0, 64'd1);
  endtask

  // Called on the negedge of demand cycle 1: assert xfer in demand cycle
  // 'delay' and keep it high for 'hold' cycles.
  task automatic respond(input int delay, input int hold, input logic [35:0] din);
    repeat (delay - 1) @(negedge clk);
    ebus_xfer_h = 1'b1;
    ebus_din_h  = din;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_demand_low", 64'(ebus_demand_h), 64'd0);
    end
    ebus_xfer_h = 1'b0;
    ebus_din_h  = '0;
  endtask

  initial begin
    int          order [6];
    int          n;
    logic [35:0] din;

    reset_l     = 1'b0;
    rq_h        = '0;
    rq_cs_h     = '0;
    rq_func_h   = '0;
    rq_wdata_h  = '0;
    ebus_xfer_h = 1'b0;
    ebus_din_h  = '0;

    #2;
    check("rst_gnt", 64'(gnt_h), 64'd0);
    check("rst_done", 64'(done_h), 64'd0);
    check("rst_tmo", 64'(tmo_h), 64'd0);
    check("rst_rdata", 64'(rdata_h), 64'd0);
    check("rst_cs", 64'(ebus_cs_h), 64'd0);
    check("rst_func", 64'(ebus_func_h), 64'd0);
    check("rst_demand", 64'(ebus_demand_h), 64'd0);
    check("rst_drive", 64'(ebus_drive_h), 64'd0);
    check("rst_dout", 64'(ebus_dout_h), 64'd0);
    repeat (3) @(negedge clk);
    reset_l = 1'b1;

    // Round-robin with all requesting, then only 0 and 3.
    order = '{0, 1, 2, 3, 0, 3};
    for (int i = 0; i < NREQ; i++) set_req(i, 7'(i + 1), 3'b000, '0);
    rq_h = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      din = 36'h0_A000_0000 + 36'(k);
      push_exp(order[k], din, 1'b0, 1);
      wait_demand();
      check("rr_gnt", 64'(gnt_h), 64'(4'b0001 << order[k]));
      if (k == 4) rq_h = 4'b1001;
      if (k == 5) rq_h = 4'b0000;
      respond(1, 1, din);
      wait_idle();
    end

    // Single read with late acknowledge; request inputs change mid-transfer.
    set_req(0, 7'o14, 3'b000, '0);
    rq_h = 4'b0001;
    push_exp(0, 36'o123456701234, 1'b0, 3);
    wait_demand();
    check("rd_gnt", 64'(gnt_h), 64'd1);
    check("rd_cs", 64'(ebus_cs_h), 64'o14);
    check("rd_drive", 64'(ebus_drive_h), 64'd0);
    rq_h = 4'b0000;
    set_req(0, 7'o77, 3'b100, 36'hF_FFFF_FFFF);
    respond(3, 1, 36'o123456701234);
    check("rd_cs_latched", 64'(ebus_cs_h), 64'o14);
    check("rd_drive_latched", 64'(ebus_drive_h), 64'd0);
    wait_idle();

    // Timeout: no acknowledge at all.
    set_req(1, 7'o21, 3'b001, '0);
    rq_h = 4'b0010;
    push_exp(1, 36'd0, 1'b1, TMO + 1);
    wait_demand();
    rq_h = 4'b0000;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ebus_demand_h) break;
      n++;
    end
    check("tmo_demand_cycles", 64'(n), 64'(TMO + 1));
    check("tmo_no_hold", 64'(done_h), 64'b0010);
    wait_idle();

    // Acknowledge on the timeout cycle, held high for 4 cycles.
    din = 36'o432104321043;
    set_req(3, 7'o5, 3'b000, '0);
    rq_h = 4'b1000;
    push_exp(3, din, 1'b0, TMO + 1);
    wait_demand();
    rq_h = 4'b0000;
    respond(TMO + 1, 4, din);
    wait_idle();

    // Write: data driven from SETUP through HOLD, read data forced to 0.
    set_req(2, 7'o3, 3'b100, 36'o777000111222);
    rq_h = 4'b0100;
    push_exp(2, 36'd0, 1'b0, 2);
    wait_gnt();
    check("wr_setup_demand", 64'(ebus_demand_h), 64'd0);
    check("wr_setup_drive", 64'(ebus_drive_h), 64'd1);
    check("wr_setup_dout", 64'(ebus_dout_h), 64'o777000111222);
    rq_h = 4'b0000;
    wait_demand();
    check("wr_demand_drive", 64'(ebus_drive_h), 64'd1);
    check("wr_demand_dout", 64'(ebus_dout_h), 64'o777000111222);
    respond(2, 1, 36'o555555555555);
    check("wr_hold_drive", 64'(ebus_drive_h), 64'd1);
    check("wr_hold_dout", 64'(ebus_dout_h), 64'o777000111222);
    @(negedge clk);
    check("wr_done_drive", 64'(ebus_drive_h), 64'd0);
    check("wr_done_dout", 64'(ebus_dout_h), 64'd0);
    wait_idle();

    // Reset in DEMAND aborts silently; first grant afterwards starts at 0.
    set_req(0, 7'o11, 3'b100, 36'h1_2345_6789);
    rq_h = 4'b0001;
    wait_demand();
    rq_h = 4'b0110;
    set_req(1, 7'o31, 3'b000, '0);
    set_req(2, 7'o32, 3'b000, '0);
    @(negedge clk);
    #2 reset_l = 1'b0;
    #1;
    check("rstm_gnt", 64'(gnt_h), 64'd0);
    check("rstm_done", 64'(done_h), 64'd0);
    check("rstm_demand", 64'(ebus_demand_h), 64'd0);
    check("rstm_drive", 64'(ebus_drive_h), 64'd0);
    check("rstm_dout", 64'(ebus_dout_h), 64'd0);
    check("rstm_cs", 64'(ebus_cs_h), 64'd0);
    @(negedge clk);
    #2 reset_l = 1'b1;
    din = 36'h9_8765_4321;
    push_exp(1, din, 1'b0, 2);
    wait_demand();
    check("rstm_first_gnt", 64'(gnt_h), 64'b0010);
    rq_h = 4'b0000;
    respond(2, 1, din);
    wait_idle();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
